// File: rtl/ecc_load_ctrl_pkg.sv
// Shared definitions for the ECC load sequencer: state encodings,
// default widths and a helper for sizing the retry counter.
package ecc_load_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;
    localparam int DATA_W     = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_CHK   = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_SCRUB = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_RD    = S_RD,
        ST_CHK   = S_CHK,
        ST_RESP  = S_RESP,
        ST_SCRUB = S_SCRUB
    } state_t;

    // Width needed to hold 0..rmax, never narrower than one bit
    function automatic int retry_w(input int rmax);
        return (rmax < 1) ? 1 : $clog2(rmax + 1);
    endfunction

endpackage

// File: rtl/ecc_load_ctrl_if.sv
// Pipeline request/response and cache/ECC port bundle for the load sequencer.
// The master side is the pipeline plus cache environment, the slave side is
// the sequencer itself.
interface ecc_load_ctrl_if
    import ecc_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              stall;
    logic              cache_rd_en;
    logic [ADDR_W-1:0] cache_addr;
    logic [31:0]       ecc_data;
    logic              ecc_sde;
    logic              ecc_te;
    logic              cache_wr_en;
    logic [31:0]       cache_wr_data;
    logic              cache_wr_ack;

    modport master (
        output req_valid, req_addr, ecc_data, ecc_sde, ecc_te, cache_wr_ack,
        input  req_ready, resp_valid, resp_data, resp_err, stall,
               cache_rd_en, cache_addr, cache_wr_en, cache_wr_data
    );

    modport slave (
        input  req_valid, req_addr, ecc_data, ecc_sde, ecc_te, cache_wr_ack,
        output req_ready, resp_valid, resp_data, resp_err, stall,
               cache_rd_en, cache_addr, cache_wr_en, cache_wr_data
    );

endinterface

// File: rtl/ecc_load_ctrl_sat_counter.sv
// Saturating statistics counter with synchronous clear that beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Count up until all-ones and stick there; clear overrides a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/ecc_load_ctrl.sv
// Sequencer for ECC-protected cache loads: issues the read, samples the
// check-and-correct result, retries uncorrectable reads a bounded number of
// times, returns the data and scrubs corrected words back into the cache.
module ecc_load_ctrl
    import ecc_load_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RETRY_MAX = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    ecc_load_ctrl_if.slave   bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    localparam int             RW        = retry_w(RETRY_MAX);
    localparam logic [RW-1:0]  RETRY_LIM = RW'(RETRY_MAX);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic              scrub_q;
    logic [RW-1:0]     retry_q;
    logic              retry_left;
    logic              inc_corr;
    logic              inc_uncorr;

    assign retry_left = (retry_q < RETRY_LIM);

    // Statistics only move on the check cycle; a triple error counts only once retries run out
    assign inc_corr   = (state == ST_CHK) && !bus.ecc_te && bus.ecc_sde;
    assign inc_uncorr = (state == ST_CHK) && bus.ecc_te && !retry_left;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a triple error takes priority over a corrected error
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.req_valid) state_nxt = ST_RD;
            ST_RD:    state_nxt = ST_CHK;
            ST_CHK:   state_nxt = (bus.ecc_te && retry_left) ? ST_RD : ST_RESP;
            ST_RESP:  state_nxt = scrub_q ? ST_SCRUB : ST_IDLE;
            ST_SCRUB: if (bus.cache_wr_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are pure decodes of the current state
    always_comb begin
        bus.req_ready   = (state == ST_IDLE);
        bus.cache_rd_en = (state == ST_RD);
        bus.stall       = (state == ST_RD) || (state == ST_CHK);
        bus.resp_valid  = (state == ST_RESP);
        bus.cache_wr_en = (state == ST_SCRUB);
    end

    assign bus.resp_data     = data_q;
    assign bus.resp_err      = err_q;
    assign bus.cache_wr_data = data_q;
    assign bus.cache_addr    = addr_q;

    // Transaction registers: address captured on accept, ECC result captured on every check
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            scrub_q <= 1'b0;
            retry_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        retry_q <= '0;
                        err_q   <= 1'b0;
                        scrub_q <= 1'b0;
                    end
                end
                ST_CHK: begin
                    data_q <= bus.ecc_data;
                    if (bus.ecc_te) begin
                        if (retry_left) begin
                            retry_q <= retry_q + 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.ecc_sde) begin
                        scrub_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_corr (
        .clk (clk),
        .rst (rst),
        .inc (inc_corr),
        .clr (clr_cnt),
        .q   (cnt_corr)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_uncorr (
        .clk (clk),
        .rst (rst),
        .inc (inc_uncorr),
        .clr (clr_cnt),
        .q   (cnt_uncorr)
    );

endmodule

// File: tb/tb_ecc_load_ctrl.sv
// Self-checking bench for ecc_load_ctrl: directed table of loads followed by
// randomized loads against a transaction-level reference model.
module tb_ecc_load_ctrl;

    import ecc_load_ctrl_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int RETRY_MAX = 2;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int N_VEC     = 13;
    localparam int N_RAND    = 40;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              sde;
        int                n_te;
        int                ack;
        logic              clr;
        int                rst_at;
        int                exp_lat;
        logic              exp_err;
        logic              exp_scrub;
        int                exp_corr;
        int                exp_uncorr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;

    int checks = 0;
    int errors = 0;

    vec_t vecs [N_VEC];

    ecc_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ecc_load_ctrl #(
        .ADDR_W    (ADDR_W),
        .RETRY_MAX (RETRY_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_cnt    (clr_cnt),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [ADDR_W-1:0] ra,
                                 input logic [31:0] ed, input logic sde,
                                 input logic te, input logic ack);
        bus.req_valid    = rv;
        bus.req_addr     = ra;
        bus.ecc_data     = ed;
        bus.ecc_sde      = sde;
        bus.ecc_te       = te;
        bus.cache_wr_ack = ack;
    endtask

    task automatic checkControl(input string tag, input logic rdy, input logic stl,
                                input logic rd, input logic rv, input logic wr);
        checkOutput({tag, " req_ready"},   bus.req_ready,   rdy);
        checkOutput({tag, " stall"},       bus.stall,       stl);
        checkOutput({tag, " cache_rd_en"}, bus.cache_rd_en, rd);
        checkOutput({tag, " resp_valid"},  bus.resp_valid,  rv);
        checkOutput({tag, " cache_wr_en"}, bus.cache_wr_en, wr);
    endtask

    task automatic checkReset(input string tag);
        checkControl(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, " resp_err"},      bus.resp_err,      0);
        checkOutput({tag, " resp_data"},     bus.resp_data,     0);
        checkOutput({tag, " cache_wr_data"}, bus.cache_wr_data, 0);
        checkOutput({tag, " cache_addr"},    bus.cache_addr,    0);
        checkOutput({tag, " cnt_corr"},      cnt_corr,          0);
        checkOutput({tag, " cnt_uncorr"},    cnt_uncorr,        0);
    endtask

    // One load, accepted at the current negedge and checked every cycle until idle
    task automatic runLoad(input vec_t v, input string tag);
        int          sd;
        int          last;
        int          idx;
        logic        te;
        logic [31:0] d;
        logic [31:0] last_data;
        string       ct;
        sd        = v.exp_scrub ? v.ack : 0;
        last      = v.exp_lat + sd + 1;
        last_data = '0;
        applyStimulus(1'b1, v.addr, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        clr_cnt = 1'b0;
        checkOutput({tag, " accept req_ready"}, bus.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= last; c++) begin
            ct = $sformatf("%s c%0d", tag, c);
            if (c < v.exp_lat && (c % 2) == 1) begin
                checkControl({ct, " RD"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                checkOutput({ct, " RD cache_addr"}, bus.cache_addr, v.addr);
            end else if (c < v.exp_lat) begin
                checkControl({ct, " CHK"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end else if (c == v.exp_lat) begin
                checkControl({ct, " RESP"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                checkOutput({ct, " resp_data"}, bus.resp_data, last_data);
                checkOutput({ct, " resp_err"},  bus.resp_err,  v.exp_err);
            end else if (c <= v.exp_lat + sd) begin
                checkControl({ct, " SCRUB"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                checkOutput({ct, " cache_wr_data"}, bus.cache_wr_data, last_data);
                checkOutput({ct, " scrub cache_addr"}, bus.cache_addr, v.addr);
            end else begin
                checkControl({ct, " IDLE"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput({ct, " cnt_corr"},   cnt_corr,   v.exp_corr);
                checkOutput({ct, " cnt_uncorr"}, cnt_uncorr, v.exp_uncorr);
            end
            if (c == v.rst_at) begin
                applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
                clr_cnt = 1'b0;
                rst     = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checkReset({tag, " after rst"});
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                checkReset({tag, " idle after rst"});
                return;
            end
            if (c == last) begin
                applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
                clr_cnt = 1'b0;
            end else begin
                if (c < v.exp_lat && (c % 2) == 0) begin
                    idx = c / 2 - 1;
                    te  = (idx < v.n_te);
                    d   = te ? (v.data ^ 32'hA5A5_0000 ^ 32'(idx)) : v.data;
                    last_data = d;
                    applyStimulus(1'($urandom), ADDR_W'($urandom), d, v.sde, te, 1'b0);
                    clr_cnt = v.clr && (c == v.exp_lat - 1);
                end else begin
                    applyStimulus(1'($urandom), ADDR_W'($urandom), $urandom,
                                  1'($urandom), 1'($urandom),
                                  (sd > 0) && (c == v.exp_lat + sd));
                    clr_cnt = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    // Watchdog so the run always ends with a summary
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog expired actual=running expected=done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Main sequence: reset, directed table, randomized loads against the model
    initial begin
        int   model_corr;
        int   model_uncorr;
        int   retries;
        vec_t rv;

        //           addr     data          sde  nte ack clr rst lat err scr corr unc
        vecs[0]  = '{10'h005, 32'hDEADBEEF, 1'b0, 0, 1, 1'b0, 0, 3, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{10'h005, 32'h12345678, 1'b1, 0, 4, 1'b0, 0, 3, 1'b0, 1'b1, 1, 0};
        vecs[2]  = '{10'h010, 32'hCAFEF00D, 1'b0, 1, 1, 1'b0, 0, 5, 1'b0, 1'b0, 1, 0};
        vecs[3]  = '{10'h3FF, 32'h0BADC0DE, 1'b0, 3, 1, 1'b0, 0, 7, 1'b1, 1'b0, 1, 1};
        vecs[4]  = '{10'h020, 32'h11111111, 1'b1, 0, 1, 1'b0, 0, 3, 1'b0, 1'b1, 2, 1};
        vecs[5]  = '{10'h021, 32'h22222222, 1'b1, 1, 2, 1'b0, 0, 5, 1'b0, 1'b1, 3, 1};
        vecs[6]  = '{10'h022, 32'h33333333, 1'b1, 0, 1, 1'b0, 0, 3, 1'b0, 1'b1, 3, 1};
        vecs[7]  = '{10'h023, 32'h44444444, 1'b1, 2, 3, 1'b0, 0, 7, 1'b0, 1'b1, 3, 1};
        vecs[8]  = '{10'h024, 32'h55555555, 1'b1, 0, 1, 1'b1, 0, 3, 1'b0, 1'b1, 0, 0};
        vecs[9]  = '{10'h00F, 32'h66666666, 1'b1, 3, 1, 1'b0, 0, 7, 1'b1, 1'b0, 0, 1};
        vecs[10] = '{10'h030, 32'h77777777, 1'b0, 0, 1, 1'b0, 2, 3, 1'b0, 1'b0, 0, 0};
        vecs[11] = '{10'h031, 32'h88888888, 1'b1, 0, 6, 1'b0, 5, 3, 1'b0, 1'b1, 0, 0};
        vecs[12] = '{10'h005, 32'h9ABCDEF0, 1'b0, 0, 1, 1'b0, 0, 3, 1'b0, 1'b0, 0, 0};

        rst     = 1'b1;
        clr_cnt = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("power-on");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < N_VEC; i++) begin
            runLoad(vecs[i], $sformatf("vec%0d", i));
        end

        model_corr   = 0;
        model_uncorr = 0;
        for (int i = 0; i < N_RAND; i++) begin
            rv.addr   = ADDR_W'($urandom);
            rv.data   = $urandom;
            rv.sde    = 1'($urandom);
            rv.n_te   = int'($urandom_range(0, RETRY_MAX + 2));
            rv.ack    = int'($urandom_range(1, 4));
            rv.clr    = ($urandom_range(0, 7) == 0);
            rv.rst_at = 0;
            retries      = (rv.n_te < RETRY_MAX) ? rv.n_te : RETRY_MAX;
            rv.exp_lat   = 3 + 2 * retries;
            rv.exp_err   = (rv.n_te > RETRY_MAX);
            rv.exp_scrub = !rv.exp_err && rv.sde;
            if (rv.clr) begin
                model_corr   = 0;
                model_uncorr = 0;
            end else begin
                if (rv.exp_scrub && model_corr < CNT_MAX) model_corr++;
                if (rv.exp_err && model_uncorr < CNT_MAX) model_uncorr++;
            end
            rv.exp_corr   = model_corr;
            rv.exp_uncorr = model_uncorr;
            runLoad(rv, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
